// File: rtl/cram_cfg_pkg.sv
// Shared state type, LE CRAM geometry and reset pattern for the CRAM configuration controller.
package cram_cfg_pkg;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        FINISH
    } state_e;

    localparam int unsigned LE_CFG_BITS = 20;
    localparam logic [LE_CFG_BITS-1:0] LE_RESET_PATTERN = 20'h20000;

    function automatic int unsigned total_bits(input int unsigned chain_len);
        return chain_len * LE_CFG_BITS;
    endfunction

endpackage

// File: rtl/cfg_serializer.sv
// Parallel-in serial-out holding register: takes one host word and emits it MSB-first.
module cfg_serializer #(
    parameter int unsigned WORD_W = 8
) (
    input  logic              clk,
    input  logic              nrst,
    input  logic              clear,
    input  logic              load,
    input  logic [WORD_W-1:0] word,
    input  logic              shift,
    output logic              msb,
    output logic              empty,
    output logic              last
);

    localparam int unsigned REM_W = $clog2(WORD_W + 1);

    logic [WORD_W-1:0] sreg_q;
    logic [REM_W-1:0]  rem_q;

    // A load may coincide with the last bit shifting out; the new word simply replaces it.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            sreg_q <= '0;
            rem_q  <= '0;
        end else if (clear) begin
            sreg_q <= '0;
            rem_q  <= '0;
        end else if (load) begin
            sreg_q <= word;
            rem_q  <= REM_W'(WORD_W);
        end else if (shift && (rem_q != '0)) begin
            sreg_q <= sreg_q << 1;
            rem_q  <= rem_q - 1'b1;
        end
    end

    assign msb   = sreg_q[WORD_W-1];
    assign empty = (rem_q == '0);
    assign last  = (rem_q == REM_W'(1));

endmodule

// File: rtl/cram_config_ctrl.sv
// Loads a daisy chain of LE CRAM shift registers from a host word stream and optionally
// checks the tail against the freshly-reset chain contents.
module cram_config_ctrl
    import cram_cfg_pkg::*;
#(
    parameter int unsigned CHAIN_LEN = 4,
    parameter int unsigned WORD_W    = 8
) (
    input  logic              clk,
    input  logic              nrst,
    input  logic              start,
    input  logic              chk_en,
    input  logic              abort,
    input  logic [WORD_W-1:0] word_in,
    input  logic              word_valid,
    output logic              word_ready,
    output logic              cfg_en,
    output logic              cfg_shift,
    output logic              cfg_data,
    input  logic              cfg_tail,
    output logic              busy,
    output logic              done,
    output logic              error
);

    localparam int unsigned TOTAL = total_bits(CHAIN_LEN);
    localparam int unsigned CNT_W = $clog2(TOTAL + 1);
    localparam int unsigned ACC_W = $clog2(TOTAL + WORD_W + 1);
    localparam int unsigned POS_W = $clog2(LE_CFG_BITS);

    localparam logic [CNT_W-1:0] LAST_BIT  = CNT_W'(TOTAL - 1);
    localparam logic [ACC_W-1:0] ACC_LIMIT = ACC_W'(TOTAL);
    localparam logic [ACC_W-1:0] ACC_STEP  = ACC_W'(WORD_W);
    localparam logic [POS_W-1:0] POS_MAX   = POS_W'(LE_CFG_BITS - 1);

    state_e           state_q;
    logic [CNT_W-1:0] bit_cnt_q;
    logic [ACC_W-1:0] acc_cnt_q;
    logic [POS_W-1:0] pos_q;
    logic             chk_q;
    logic             error_q;

    logic in_load, shift_now, final_shift, accept, ser_clear;
    logic ser_msb, ser_empty, ser_last;
    logic tail_exp, mismatch;

    assign in_load     = (state_q == LOAD);
    assign shift_now   = in_load && !ser_empty;
    assign final_shift = shift_now && (bit_cnt_q == LAST_BIT);
    // acc_cnt counts bits already accepted, so the word holding bit TOTAL-1 is the last one taken.
    assign word_ready  = in_load && (acc_cnt_q < ACC_LIMIT) && (ser_empty || ser_last);
    assign accept      = word_valid && word_ready;
    assign ser_clear   = !in_load || abort || final_shift;

    assign tail_exp = LE_RESET_PATTERN[POS_MAX - pos_q];
    assign mismatch = chk_q && shift_now && (cfg_tail != tail_exp);

    cfg_serializer #(
        .WORD_W(WORD_W)
    ) u_ser (
        .clk  (clk),
        .nrst (nrst),
        .clear(ser_clear),
        .load (accept),
        .word (word_in),
        .shift(shift_now),
        .msb  (ser_msb),
        .empty(ser_empty),
        .last (ser_last)
    );

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_q   <= IDLE;
            bit_cnt_q <= '0;
            acc_cnt_q <= '0;
            pos_q     <= '0;
            chk_q     <= 1'b0;
            error_q   <= 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (start) begin
                        state_q   <= LOAD;
                        error_q   <= 1'b0;
                        chk_q     <= chk_en;
                        bit_cnt_q <= '0;
                        acc_cnt_q <= '0;
                        pos_q     <= '0;
                    end
                end
                LOAD: begin
                    if (accept) begin
                        acc_cnt_q <= acc_cnt_q + ACC_STEP;
                    end
                    if (shift_now) begin
                        bit_cnt_q <= bit_cnt_q + 1'b1;
                        pos_q     <= (pos_q == POS_MAX) ? '0 : pos_q + 1'b1;
                    end
                    // Abort takes priority over a coincident final shift.
                    if (abort) begin
                        state_q <= IDLE;
                        error_q <= 1'b1;
                    end else begin
                        if (mismatch) begin
                            error_q <= 1'b1;
                        end
                        if (final_shift) begin
                            state_q <= FINISH;
                        end
                    end
                end
                FINISH: state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    assign cfg_en    = in_load;
    assign busy      = in_load;
    assign cfg_shift = shift_now;
    assign cfg_data  = shift_now && ser_msb;
    assign done      = (state_q == FINISH);
    assign error     = error_q;

endmodule

// File: tb/tb_cram_config_ctrl.sv
// Bench for cram_config_ctrl: a CHAIN_LEN=2 and a CHAIN_LEN=1 instance, a bit scoreboard
// for the serial stream and a reset-state LE chain model feeding cfg_tail.
module tb_cram_config_ctrl;

    localparam logic [19:0] PAT = 20'h20000;

    logic       clk = 1'b0;
    logic       nrst = 1'b1;
    logic       sel = 1'b0;
    logic       start_drv = 1'b0;
    logic       chk_en = 1'b0;
    logic       abort = 1'b0;
    logic       word_valid = 1'b0;
    logic [7:0] word_in = '0;
    logic       tail_in;

    logic a_ready, a_en, a_shift, a_data, a_busy, a_done, a_error;
    logic b_ready, b_en, b_shift, b_data, b_busy, b_done, b_error;
    logic o_ready, o_cfg_en, o_shift, o_data, o_busy, o_done, o_error;

    always #5 clk = ~clk;

    cram_config_ctrl #(.CHAIN_LEN(2), .WORD_W(8)) dut_a (
        .clk(clk), .nrst(nrst), .start(start_drv & ~sel), .chk_en(chk_en), .abort(abort),
        .word_in(word_in), .word_valid(word_valid), .word_ready(a_ready), .cfg_en(a_en),
        .cfg_shift(a_shift), .cfg_data(a_data), .cfg_tail(tail_in), .busy(a_busy),
        .done(a_done), .error(a_error)
    );

    cram_config_ctrl #(.CHAIN_LEN(1), .WORD_W(8)) dut_b (
        .clk(clk), .nrst(nrst), .start(start_drv & sel), .chk_en(chk_en), .abort(abort),
        .word_in(word_in), .word_valid(word_valid), .word_ready(b_ready), .cfg_en(b_en),
        .cfg_shift(b_shift), .cfg_data(b_data), .cfg_tail(tail_in), .busy(b_busy),
        .done(b_done), .error(b_error)
    );

    assign o_ready  = sel ? b_ready : a_ready;
    assign o_cfg_en = sel ? b_en    : a_en;
    assign o_shift  = sel ? b_shift : a_shift;
    assign o_data   = sel ? b_data  : a_data;
    assign o_busy   = sel ? b_busy  : a_busy;
    assign o_done   = sel ? b_done  : a_done;
    assign o_error  = sel ? b_error : a_error;

    // Freshly-reset LE chain: 40 bits, tail at bit 39 (two LEs) or bit 19 (one LE).
    logic [39:0] chain;
    logic        cap_shift = 1'b0;
    logic        cap_data = 1'b0;
    int          force_k = -1;
    int          k_now = -1;

    always @(posedge clk or negedge nrst) begin
        if (!nrst) chain <= {PAT, PAT};
        else if (cap_shift) chain <= {chain[38:0], cap_data};
    end

    assign tail_in = (force_k >= 0 && k_now == force_k) ? 1'b1 : (sel ? chain[19] : chain[39]);

    int n_vec = 0, n_fail = 0;
    int cyc, shifts, done_cnt, last_shift_cyc, done_cyc, starve;
    int words_acc, bits_pushed, total, nwords, gap_after, gap_len, withheld, abort_at;
    bit stream_en, aborted, start_pend;
    logic [7:0] words[8];
    bit q[$];

    typedef struct {
        int sel;        int nwords;     int gap_after;  int gap_len;   int chk;
        int force_k;    int exp_shifts; int exp_words;  int exp_starve; int exp_err;
    } vec_t;
    vec_t vecs[6];

    task automatic chk(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic cycle();
        bit exp_bit;
        @(negedge clk);
        cyc++;
        cap_shift = o_shift;
        cap_data  = o_data;
        if (o_shift) begin
            if (q.size() == 0) chk("data_underflow", 1, 0);
            else begin
                exp_bit = q.pop_front();
                chk("cfg_data", int'(o_data), int'(exp_bit));
            end
            k_now = shifts;
            shifts++;
            last_shift_cyc = cyc;
        end else begin
            k_now = -1;
            if (o_busy && shifts > 0) starve++;
        end
        if (o_done) begin
            done_cnt++;
            done_cyc = cyc;
        end
        start_drv  = start_pend;
        start_pend = 0;
        abort      = 0;
        if (abort_at >= 0 && !aborted && shifts == abort_at) begin
            abort = 1;
            aborted = 1;
            stream_en = 0;
        end
        word_valid = 0;
        if (stream_en && words_acc < nwords) begin
            if (gap_after >= 0 && words_acc == gap_after + 1 && withheld < gap_len) begin
                if (o_ready) withheld++;
            end else begin
                word_valid = 1;
                word_in = words[words_acc];
            end
        end
        if (word_valid && o_ready) begin
            for (int i = 7; i >= 0; i--) begin
                if (bits_pushed < total) begin
                    q.push_back(word_in[i]);
                    bits_pushed++;
                end
            end
            words_acc++;
        end
    endtask

    task automatic do_reset();
        nrst = 0;
        start_pend = 0; start_drv = 0; abort = 0; word_valid = 0; cap_shift = 0; k_now = -1;
        repeat (2) @(negedge clk);
        nrst = 1;
    endtask

    task automatic run(input int s, input bit rst, input int nw, input int ga, input int gl,
                       input bit ce, input int fk, input int ab, input int ra);
        bit timeout;
        sel = (s != 0);
        if (rst) do_reset();
        total = sel ? 20 : 40;
        q.delete();
        cyc = 0; shifts = 0; done_cnt = 0; last_shift_cyc = -1; done_cyc = -1; starve = 0;
        words_acc = 0; bits_pushed = 0; withheld = 0; aborted = 0; stream_en = 1;
        nwords = nw; gap_after = ga; gap_len = gl; force_k = fk; abort_at = ab;
        for (int i = 0; i < 8; i++) words[i] = 8'($urandom);
        chk_en = ce;
        start_pend = 1;
        cycle();
        cycle();
        chk("busy_on_start", int'(o_busy), 1);
        chk("cfg_en_on_start", int'(o_cfg_en), 1);
        chk("error_cleared", int'(o_error), 0);
        chk("no_shift_first", int'(o_shift), 0);
        timeout = 1;
        for (int n = 0; n < 300; n++) begin
            cycle();
            if (done_cnt != 0) begin
                timeout = 0;
                break;
            end
            if (aborted) begin
                cycle();
                chk("abort_busy", int'(o_busy), 0);
                chk("abort_cfg_en", int'(o_cfg_en), 0);
                chk("abort_shift", int'(o_shift), 0);
                chk("abort_error", int'(o_error), 1);
                repeat (5) cycle();
                chk("abort_error_sticky", int'(o_error), 1);
                timeout = 0;
                break;
            end
            if (ra >= 0 && shifts == ra) begin
                #2 nrst = 0;
                #1;
                chk("rst_word_ready", int'(o_ready), 0);
                chk("rst_cfg_en", int'(o_cfg_en), 0);
                chk("rst_cfg_shift", int'(o_shift), 0);
                chk("rst_cfg_data", int'(o_data), 0);
                chk("rst_busy", int'(o_busy), 0);
                chk("rst_done", int'(o_done), 0);
                chk("rst_error", int'(o_error), 0);
                @(negedge clk);
                cap_shift = 0;
                nrst = 1;
                for (int c = 0; c < 4; c++) begin
                    cycle();
                    chk("post_rst_ready", int'(o_ready), 0);
                    chk("post_rst_busy", int'(o_busy), 0);
                end
                timeout = 0;
                break;
            end
        end
        if (timeout) chk("timeout", 1, 0);
        else repeat (3) cycle();
    endtask

    initial begin
        // sel, nwords, gap_after, gap_len, chk, force_k, exp_shifts, exp_words, exp_starve, exp_err
        vecs[0] = '{0, 5, -1, 0, 0, -1, 40, 5, 0, 0};
        vecs[1] = '{0, 5,  2, 3, 0, -1, 40, 5, 3, 0};
        vecs[2] = '{1, 4, -1, 0, 0, -1, 20, 3, 0, 0};
        vecs[3] = '{0, 5, -1, 0, 1, -1, 40, 5, 0, 0};
        vecs[4] = '{0, 5, -1, 0, 1,  5, 40, 5, 0, 1};
        vecs[5] = '{1, 4, -1, 0, 1, -1, 20, 3, 0, 0};

        #1 nrst = 0;
        #1;
        chk("reset_word_ready", int'(o_ready), 0);
        chk("reset_cfg_en", int'(o_cfg_en), 0);
        chk("reset_cfg_shift", int'(o_shift), 0);
        chk("reset_cfg_data", int'(o_data), 0);
        chk("reset_busy", int'(o_busy), 0);
        chk("reset_done", int'(o_done), 0);
        chk("reset_error", int'(o_error), 0);

        foreach (vecs[v]) begin
            run(vecs[v].sel, 1, vecs[v].nwords, vecs[v].gap_after, vecs[v].gap_len,
                vecs[v].chk != 0, vecs[v].force_k, -1, -1);
            chk("shift_count", shifts, vecs[v].exp_shifts);
            chk("words_accepted", words_acc, vecs[v].exp_words);
            chk("starve_cycles", starve, vecs[v].exp_starve);
            chk("done_count", done_cnt, 1);
            chk("done_timing", done_cyc, last_shift_cyc + 1);
            chk("error_final", int'(o_error), vecs[v].exp_err);
            chk("stream_drained", q.size(), 0);
        end

        // Abort after 12 shifts, then a fresh start without reset must clear error and complete.
        run(0, 1, 5, -1, 0, 0, -1, 12, -1);
        chk("abort_shifts", shifts, 12);
        chk("abort_no_done", done_cnt, 0);
        run(0, 0, 5, -1, 0, 0, -1, -1, -1);
        chk("reload_shifts", shifts, 40);
        chk("reload_done", done_cnt, 1);
        chk("reload_error", int'(o_error), 0);

        // Asynchronous reset after 17 shifts.
        run(0, 1, 5, -1, 0, 0, -1, -1, 17);
        chk("rst_mid_shifts", shifts, 17);
        chk("rst_mid_no_done", done_cnt, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
